// File: rtl/switch_pkg.sv
// ============================================================================
// Module   : switch_pkg
// Brief    : Shared types and constants for the switch ring scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int SLOT_W    = 20;
  localparam int STARVE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2
  } phase_e;

  // First starved port found scanning own, own+1, ... modulo 4.
  function automatic logic [1:0] pick_starved(input logic [3:0] st,
                                              input logic [1:0] own);
    logic [1:0] idx;
    logic       found;
    pick_starved = own;
    found        = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = own + 2'(k);
      if (!found && st[idx]) begin
        pick_starved = idx;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_starve_ctr.sv
// ============================================================================
// Module   : switch_starve_ctr
// Brief    : Per-port saturating starvation counter with clear/inc/sat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_starve_ctr
  import switch_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [STARVE_W-1:0] C_LIMIT = STARVE_W'(LIMIT);

  logic [STARVE_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (en) begin
      if (clr) begin
        r_count <= '0;
      end else if (inc && (r_count != C_LIMIT)) begin
        r_count <= r_count + STARVE_W'(1);
      end
    end
  end

  assign sat = (r_count == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/switch_ring_sched.sv
// ============================================================================
// Module   : switch_ring_sched
// Brief    : CHECK/SHIFT ring sequencer with starvation-aware inject grants.
//            Optional statistics outputs with SWITCH_SCHED_STATS_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_ring_sched
  import switch_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_PORTS-1:0] in_req,
  input  logic [NUM_PORTS-1:0] slot_up_busy,
  input  logic [NUM_PORTS-1:0] slot_hit,
  input  logic [NUM_PORTS-1:0] out_full,
  output logic [1:0]           phase,
  output logic [NUM_PORTS-1:0] deliver_en,
  output logic [NUM_PORTS-1:0] inject_grant,
  output logic [NUM_PORTS-1:0] starved,
  output logic [1:0]           owner
`ifdef SWITCH_SCHED_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][15:0] grant_cnt,
  output logic [15:0]                starve_evt_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_CHECK = CHECK;
  localparam logic [1:0] ST_SHIFT = SHIFT;

  logic [1:0]           r_phase;
  logic [1:0]           w_phase_nxt;
  logic [1:0]           r_owner;
  logic [1:0]           w_sel;
  logic                 w_any_starved;
  logic                 w_is_shift;
  logic                 w_is_check;
  logic [NUM_PORTS-1:0] w_inhibit;
  logic [NUM_PORTS-1:0] w_grant;

  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      ST_IDLE:  if (enable) w_phase_nxt = ST_CHECK;
      ST_CHECK: w_phase_nxt = ST_SHIFT;
      ST_SHIFT: w_phase_nxt = enable ? ST_CHECK : ST_IDLE;
      default:  w_phase_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= ST_IDLE;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // Gating with reset kills grants in the same cycle reset rises.
  assign w_is_shift = (r_phase == ST_SHIFT) & ~reset;
  assign w_is_check = (r_phase == ST_CHECK) & ~reset;

  assign w_any_starved = |starved;
  assign w_sel         = pick_starved(starved, r_owner);
  assign w_inhibit     = w_any_starved ? ~(NUM_PORTS'(1) << w_sel) : '0;

  assign w_grant      = {NUM_PORTS{w_is_shift}} & in_req & ~slot_up_busy & ~w_inhibit;
  assign inject_grant = w_grant;
  assign deliver_en   = {NUM_PORTS{w_is_check}} & slot_hit & ~out_full;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ctr
      switch_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
      ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (w_is_shift),
        .clr   (w_grant[i] | ~in_req[i]),
        .inc   (in_req[i] & ~w_grant[i]),
        .sat   (starved[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner <= 2'd0;
    end else if (w_is_shift && w_any_starved && w_grant[w_sel]) begin
      r_owner <= r_owner + 2'd1;
    end
  end

  assign phase = r_phase;
  assign owner = r_owner;

`ifdef SWITCH_SCHED_STATS_EN
  logic [NUM_PORTS-1:0] r_starved_d;

  generate
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_stats
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          grant_cnt[i] <= '0;
        end else if (w_grant[i]) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  endgenerate

  // A starve event is a counter newly arriving at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starved_d    <= '0;
      starve_evt_cnt <= '0;
    end else begin
      r_starved_d <= starved;
      if (|(starved & ~r_starved_d)) begin
        starve_evt_cnt <= starve_evt_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/switch_ring_sched.md
SWITCH_RING_SCHED -- requirements
Module: switch_ring_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, range 2-255: the number of SHIFT phases in which a port may request and be denied before it is marked starved.
REQ-002 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port enable, input, 1: run request for the ring sequencer.
REQ-005 SHALL have port in_req, input, 4: input FIFO i is non-empty.
REQ-006 SHALL have port slot_up_busy, input, 4: the ring slot feeding slot i carries a packet after delivery.
REQ-007 SHALL have port slot_hit, input, 4: slot i holds a packet whose destination mask has bit i set.
REQ-008 SHALL have port out_full, input, 4: output FIFO i holds 4 entries.
REQ-009 SHALL have port phase, output, 2: 0=IDLE, 1=CHECK, 2=SHIFT.
REQ-010 SHALL have port deliver_en, output, 4: in CHECK, move slot i to output FIFO i.
REQ-011 SHALL have port inject_grant, output, 4: in SHIFT, pop input FIFO i into slot i.
REQ-012 SHALL have port starved, output, 4: starve counter i is at STARVE_LIMIT.
REQ-013 SHALL have port owner, output, 2: current round-robin starvation owner pointer.

Function
REQ-014 SHALL implement the FSM IDLE->CHECK when enable=1, CHECK->SHIFT unconditionally, SHIFT->CHECK when enable=1, and SHIFT->IDLE when enable=0.
REQ-015 SHALL leave CHECK when enable drops during CHECK only after completing the following SHIFT.
REQ-016 SHALL drive deliver_en[i] = (phase==CHECK) & slot_hit[i] & ~out_full[i], combinationally, and drive 0 in other phases.
REQ-017 SHALL drive inject_grant[i] = (phase==SHIFT) & in_req[i] & ~slot_up_busy[i] & ~inhibit[i], combinationally.
REQ-018 SHALL set inhibit[i]=1 only when some port is starved, and i is not the selected starved port.
REQ-019 SHALL select as the starved port the first starved port found scanning owner, owner+1, ... modulo 4.
REQ-020 SHALL update each starve counter once per SHIFT cycle:
- clear on grant, or when in_req[i]=0;
- increment when in_req[i]=1 and there is no grant, saturating at STARVE_LIMIT.
REQ-021 SHALL advance owner by 1 (modulo 4, 3->0) in any SHIFT cycle where the selected starved port is granted.
REQ-022 SHALL leave owner unchanged when no port is starved.
REQ-023 SHALL hold starve counters and owner unchanged in the IDLE and CHECK phases.
REQ-024 SHALL give zero added latency: grants and deliveries are combinational in their phase cycle, and counters update on the closing edge of that cycle.

Reset
REQ-025 SHALL, on reset, set phase=IDLE, owner=0, all starve counters=0, deliver_en=0, inject_grant=0 and starved=0, asynchronously.
REQ-026 SHALL, on reset asserted mid-SHIFT, suppress grants immediately, so that no FIFO pop occurs.

Configuration
REQ-027 SHALL, with SWITCH_SCHED_STATS_EN defined, add outputs grant_cnt[4][16] and starve_evt_cnt[16]:
- grant_cnt[i] wraps and increments per inject_grant[i];
- starve_evt_cnt increments when any counter first reaches STARVE_LIMIT;
- both reset to 0.
REQ-028 SHALL, without SWITCH_SCHED_STATS_EN, omit these ports and their logic entirely.

Structure
REQ-029 SHALL place the phase enum (IDLE, CHECK, SHIFT), the port count 4 and the slot width 20 in the shared package switch_pkg.
REQ-030 SHALL instantiate one sub-module, switch_starve_ctr: a per-port saturating counter with clear/inc/sat, four instances.

Verification
REQ-031 SHALL cover sequencing: enable=1 from reset -> phase 0,1,2,1,2...; enable=0 in CHECK -> the following SHIFT completes, then phase=0.
REQ-032 SHALL cover delivery: slot_hit=4'b1010, out_full=4'b0010 in CHECK -> deliver_en=4'b1000; the same inputs in SHIFT -> 0.
REQ-033 SHALL cover injection: in_req=4'hF, slot_up_busy=4'b0101, no starvation -> inject_grant=4'b1010.
REQ-034 SHALL cover starvation: in_req[0]=1, slot_up_busy[0]=1 for 8 SHIFTs -> starved=4'b0001, inject_grant[3:1]=0 thereafter; slot_up_busy[0]=0 -> grant[0]=1, owner 0->1, counter 0.
REQ-035 SHALL cover owner selection: ports 1 and 3 both starved with owner=2 -> port 3 selected and port 1 inhibited; after port 3 is granted, owner=3 and port 1 is selected.
REQ-036 SHALL cover reset mid-operation: reset asserted in SHIFT with grants active -> all outputs 0 within the same cycle, and counters and owner at 0.
